// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU op sequencer
//   ACC_W    : accumulator width
//   OP_REP_W : width of the per-op repeat count carried in op_t
//   func_e   : ALU function code (add, mul, shl, hold)
//   state_e  : sequencer FSM states
//   op_t     : one queued op (operand A, function, extra repetitions)
package alu_seq_pkg;
   localparam int ACC_W = 8;
   localparam int OP_REP_W = 3;
   typedef enum logic [1:0] {F_ADD, F_MUL, F_SHL, F_HOLD} func_e;
   typedef enum logic {S_IDLE, S_EXEC} state_e;
   typedef struct packed {
      logic [3:0]          data;
      func_e               func;
      logic [OP_REP_W-1:0] rep;
   } op_t;
endpackage

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo: synchronous FIFO of DEPTH op_t entries
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : store din when push is high (caller keeps push low when full)
//   pop, dout  : dout is the head entry; pop drops it (caller keeps pop low when empty)
//   full, empty, count : occupancy; push and pop together leave count unchanged
module alu_seq_fifo
   import alu_seq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  op_t                    din,
   input  logic                   pop,
   output op_t                    dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   op_t           mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end
   assign dout  = mem[rd_ptr];
   assign full  = count == CW'(DEPTH);
   assign empty = count == '0;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues ALU ops and applies each one rep+1 times to an 8-bit accumulator
//   clk, rst          : clock, synchronous active-high reset (discards queued and in-flight ops)
//   op_valid/op_ready : op handshake; op_ready while the FIFO holds fewer than DEPTH ops
//   op_data, op_func  : operand A and function (00 add, 01 mul, 10 shl, 11 hold)
//   op_rep            : extra repetitions of the op
//   acc_out           : accumulator; B operand is acc_out[3:0]
//   busy              : executing or ops queued
//   done              : one-cycle pulse after an op's final application
//   ops_done          : count of done pulses, present only when SEQ_OPCNT_EN is defined
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int REP_W = OP_REP_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [3:0]       op_data,
   input  logic [1:0]       op_func,
   input  logic [REP_W-1:0] op_rep,
   output logic [ACC_W-1:0] acc_out,
   output logic             busy,
   output logic             done
`ifdef SEQ_OPCNT_EN
   ,
   output logic [7:0]       ops_done
`endif
);
   localparam int CW = $clog2(DEPTH) + 1;
   op_t              din, head;
   logic             full, empty, push, pop;
   logic [CW-1:0]    count;
   state_e           state;
   logic [3:0]       op_a;
   func_e            op_f;
   logic [REP_W-1:0] rep_cnt;
   logic [ACC_W-1:0] alu_res;
   assign din      = '{data: op_data, func: func_e'(op_func), rep: op_rep};
   assign op_ready = count < CW'(DEPTH);
   assign push     = op_valid & ~full;
   // Pop when leaving IDLE or on the final application, so queued ops run without a bubble.
   assign pop      = ~empty & ((state == S_IDLE) | (rep_cnt == '0));
   assign busy     = (state == S_EXEC) | ~empty;
   // Shifts of 8 or more clear the result; op_a[3] flags that case.
   assign alu_res  = op_f == F_ADD ? ACC_W'(op_a) + ACC_W'(acc_out[3:0])
                   : op_f == F_MUL ? ACC_W'(op_a) * ACC_W'(acc_out[3:0])
                   : op_f == F_SHL ? (op_a[3] ? '0 : ACC_W'(acc_out[3:0]) << op_a[2:0])
                   : acc_out;
   alu_seq_fifo #(.DEPTH(DEPTH)) fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .din  (din),
      .pop  (pop),
      .dout (head),
      .full (full),
      .empty(empty),
      .count(count)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         acc_out <= '0;
         done    <= 1'b0;
         op_a    <= '0;
         op_f    <= F_HOLD;
         rep_cnt <= '0;
`ifdef SEQ_OPCNT_EN
         ops_done <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (state == S_EXEC) begin
            acc_out <= alu_res;
            if (rep_cnt != '0) rep_cnt <= rep_cnt - REP_W'(1);
            else begin
               done <= 1'b1;
`ifdef SEQ_OPCNT_EN
               ops_done <= ops_done + 8'd1;
`endif
               if (empty) state <= S_IDLE;
            end
         end
         if (pop) begin
            op_a    <= head.data;
            op_f    <= head.func;
            rep_cnt <= head.rep;
            state   <= S_EXEC;
         end
      end
   end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench; expected accumulator trace and timing come from an op-level model
module tb_alu_op_sequencer;
   logic       clk = 1'b0, rst = 1'b1, op_valid = 1'b0;
   logic       op_ready, busy, done;
   logic [3:0] op_data = '0;
   logic [1:0] op_func = '0;
   logic [2:0] op_rep = '0;
   logic [7:0] acc_out;
`ifdef SEQ_OPCNT_EN
   logic [7:0] ops_done;
`endif
   always #5 clk = ~clk;

   alu_op_sequencer #(.DEPTH(4), .REP_W(3)) dut (
      .clk     (clk),
      .rst     (rst),
      .op_valid(op_valid),
      .op_ready(op_ready),
      .op_data (op_data),
      .op_func (op_func),
      .op_rep  (op_rep),
      .acc_out (acc_out),
      .busy    (busy),
      .done    (done)
`ifdef SEQ_OPCNT_EN
      ,
      .ops_done(ops_done)
`endif
   );

   // p: accept edge, q: pop edge, w: first write edge, f: final write edge
   typedef struct {
      int p, q, w, f, r;
      logic [7:0][7:0] vals;
   } exp_t;
   exp_t       sb[$];
   int         cyc = 0, n_chk = 0, n_fail = 0, last_final = 0, opcnt = 0;
   logic [7:0] acc_m = '0, settled = '0;
   bit         in_reset = 1'b1;

   always @(posedge clk) cyc++;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [7:0] ref_alu(logic [7:0] acc, int a, int f);
      int b;
      b = acc % 16;
      if (f == 0) return 8'(a + b);
      if (f == 1) return 8'(a * b);
      if (f == 2) return a >= 8 ? 8'(0) : 8'((b * (2 ** a)) % 256);
      return acc;
   endfunction

   task automatic model_accept(int d, int f, int r);
      exp_t       e;
      logic [7:0] a;
      a   = acc_m;
      e.p = cyc + 1;
      e.q = (e.p + 1 > last_final) ? e.p + 1 : last_final;
      e.w = e.q + 1;
      e.f = e.q + r + 1;
      e.r = r;
      e.vals = '0;
      for (int i = 0; i <= r; i++) begin
         a = ref_alu(a, d, f);
         e.vals[i] = a;
      end
      acc_m = a;
      last_final = e.f;
      sb.push_back(e);
   endtask

   task automatic push_op(int d, int f, int r);
      int k;
      k = 0;
      op_valid = 1'b1;
      op_data = 4'(d);
      op_func = 2'(f);
      op_rep = 3'(r);
      while (!op_ready && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      if (!op_ready) begin
         check("push_timeout", op_ready, 1);
         op_valid = 1'b0;
         return;
      end
      model_accept(d, f, r);
      @(posedge clk); #1;
      op_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (sb.size() != 0 && k < 600) begin
         @(posedge clk); #1;
         k++;
      end
      check("drain", sb.size(), 0);
   endtask

   task automatic do_reset(int n);
      in_reset = 1'b1;
      op_valid = 1'b0;
      rst = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      acc_m = '0;
      settled = '0;
      opcnt = 0;
      last_final = cyc;
      check("reset_acc", acc_out, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_ready", op_ready, 1);
`ifdef SEQ_OPCNT_EN
      check("reset_ops_done", ops_done, 0);
`endif
      in_reset = 1'b0;
   endtask

   always @(negedge clk) begin : monitor
      int         cnt;
      bit         bz, exp_done;
      logic [7:0] exp_acc;
      if (!in_reset) begin
         cnt = 0;
         bz = 1'b0;
         foreach (sb[i]) begin
            if (sb[i].p <= cyc && sb[i].q > cyc) cnt++;
            if (sb[i].p <= cyc && cyc < sb[i].f) bz = 1'b1;
         end
         exp_done = sb.size() != 0 && sb[0].f == cyc;
         exp_acc = (sb.size() != 0 && cyc >= sb[0].w) ? sb[0].vals[cyc - sb[0].w] : settled;
         check("op_ready", op_ready, cnt < 4);
         check("busy", busy, bz);
         check("done", done, exp_done);
         check("acc_out", acc_out, exp_acc);
         if (exp_done) begin
            settled = sb[0].vals[sb[0].r];
            opcnt++;
            void'(sb.pop_front());
         end
`ifdef SEQ_OPCNT_EN
         check("ops_done", ops_done, opcnt % 256);
`endif
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      do_reset(2);
      push_op(5, 0, 0);
      wait_idle();
      push_op(3, 1, 2);
      wait_idle();
      push_op(4, 2, 0);
      push_op(9, 2, 0);
      wait_idle();
      push_op(1, 3, 7);
      for (int i = 0; i < 5; i++) push_op($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3));
      wait_idle();
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1;
         end
         push_op($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 7));
      end
      wait_idle();
      push_op(2, 0, 7);
      push_op(3, 1, 1);
      repeat (4) @(posedge clk);
      #1;
      do_reset(1);
      push_op(6, 0, 1);
      wait_idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
